// File: rtl/pipeline_hazard_ctrl_ysyx_23060136.sv
// Stall/flush controller for the 5-stage pipeline: resolves LSU wait, EX redirect,
// load-use and fetch-not-ready hazards, latches halt and counts stall cycles.
//
// state  | meaning
// M_IDLE | no LSU access outstanding
// M_WAIT | MEM access issued, waiting for LSU_o_done
module pipeline_hazard_ctrl_ysyx_23060136 #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 IFU_o_valid,
  input  logic [4:0]           IDU_o_rs1,
  input  logic [4:0]           IDU_o_rs2,
  input  logic                 IDU_o_use_rs1,
  input  logic                 IDU_o_use_rs2,
  input  logic                 EXU_o_mem_to_reg,
  input  logic [4:0]           EXU_o_rd,
  input  logic                 EXU_o_redirect,
  input  logic                 MEM_o_mem_req,
  input  logic                 LSU_o_done,
  input  logic                 WB_i_system_halt,
  output logic                 FORWARD_stallIF,
  output logic                 FORWARD_stallID,
  output logic                 FORWARD_stallEX,
  output logic                 FORWARD_stallME,
  output logic                 FORWARD_stallWB,
  output logic                 FORWARD_flushIF,
  output logic                 FORWARD_flushID,
  output logic                 FORWARD_flushEX,
  output logic                 FORWARD_flushME,
  output logic                 ctrl_halted,
  output logic [CNT_WIDTH-1:0] ctrl_stall_cnt
);

  localparam logic [0:0] M_IDLE = 1'b0;
  localparam logic [0:0] M_WAIT = 1'b1;

  logic [0:0]           mem_state_q, mem_state_d;
  logic                 kill_q, kill_d;
  logic                 halted_q, halted_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic mem_stall;
  logic load_use;
  logic fetch_stall;
  logic redirect_take;

  always_comb begin
    mem_stall = 1'b0;
    if (mem_state_q == M_WAIT) mem_stall = ~LSU_o_done;
    else                       mem_stall = MEM_o_mem_req & ~LSU_o_done;
  end

  assign load_use = EXU_o_mem_to_reg && (EXU_o_rd != 5'd0) &&
                    ((IDU_o_use_rs1 && (IDU_o_rs1 == EXU_o_rd)) ||
                     (IDU_o_use_rs2 && (IDU_o_rs2 == EXU_o_rd)));

  assign fetch_stall = ~IFU_o_valid | kill_q;

  // A redirect only takes effect when neither halt nor the LSU wait holds EX.
  assign redirect_take = ~halted_q & ~mem_stall & EXU_o_redirect;

  always_comb begin
    FORWARD_stallIF = 1'b0;
    FORWARD_stallID = 1'b0;
    FORWARD_stallEX = 1'b0;
    FORWARD_stallME = 1'b0;
    FORWARD_stallWB = 1'b0;
    FORWARD_flushIF = 1'b0;
    FORWARD_flushID = 1'b0;
    FORWARD_flushEX = 1'b0;
    FORWARD_flushME = 1'b0;
    if (!rst) begin
      if (halted_q) begin
        FORWARD_stallIF = 1'b1;
        FORWARD_stallID = 1'b1;
        FORWARD_stallEX = 1'b1;
        FORWARD_stallME = 1'b1;
        FORWARD_stallWB = 1'b1;
      end else if (mem_stall) begin
        FORWARD_stallIF = 1'b1;
        FORWARD_stallID = 1'b1;
        FORWARD_stallEX = 1'b1;
        FORWARD_stallME = 1'b1;
        FORWARD_flushME = 1'b1;
      end else if (EXU_o_redirect) begin
        FORWARD_flushIF = 1'b1;
        FORWARD_flushID = 1'b1;
      end else if (load_use) begin
        FORWARD_stallIF = 1'b1;
        FORWARD_stallID = 1'b1;
        FORWARD_flushID = 1'b1;
      end else if (fetch_stall) begin
        FORWARD_stallIF = 1'b1;
        FORWARD_flushIF = 1'b1;
      end
    end
  end

  always_comb begin
    mem_state_d = mem_state_q;
    if (mem_state_q == M_IDLE) begin
      if (mem_stall) mem_state_d = M_WAIT;
    end else if (LSU_o_done) begin
      mem_state_d = M_IDLE;
    end

    // Redirect with no valid fetch leaves a stale instruction in flight.
    kill_d = kill_q;
    if (redirect_take) begin
      if (!IFU_o_valid) kill_d = 1'b1;
    end else if (IFU_o_valid) begin
      kill_d = 1'b0;
    end

    halted_d = halted_q | WB_i_system_halt;

    cnt_d = cnt_q;
    if (FORWARD_stallIF && !halted_q && (cnt_q != {CNT_WIDTH{1'b1}}))
      cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_state_q <= M_IDLE;
      kill_q      <= 1'b0;
      halted_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      mem_state_q <= mem_state_d;
      kill_q      <= kill_d;
      halted_q    <= halted_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ctrl_halted    = halted_q;
  assign ctrl_stall_cnt = cnt_q;

endmodule

// File: doc/pipeline_hazard_ctrl_ysyx_23060136.md
Name: pipeline_hazard_ctrl_ysyx_23060136

Overview:
Central stall/flush controller for the 5-stage pipeline (IF, ID, EX, MEM, WB). It drives the FORWARD_stall*/FORWARD_flush* inputs of the PC and of the IF_ID, ID_EX, EX_MEM and MEM_WB segment registers. It resolves four hazard sources: LSU wait, EX redirect, load-use, and fetch not ready. It also tracks a pending fetch-kill after a redirect, latches system halt, and counts stall cycles.

Parameters:
CNT_WIDTH, 32, width of the stall-cycle performance counter

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
IFU_o_valid  input  1  IF holds a fetched instruction this cycle
IDU_o_rs1  input  5  ID source register 1
IDU_o_rs2  input  5  ID source register 2
IDU_o_use_rs1  input  1  ID instruction reads rs1
IDU_o_use_rs2  input  1  ID instruction reads rs2
EXU_o_mem_to_reg  input  1  EX instruction is a load
EXU_o_rd  input  5  EX destination register
EXU_o_redirect  input  1  EX resolved taken branch/jump/trap; PC loads target this cycle
MEM_o_mem_req  input  1  MEM instruction needs LSU (load/store)
LSU_o_done  input  1  LSU response pulse, one cycle
WB_i_system_halt  input  1  halting instruction is in WB
FORWARD_stallIF  output  1  hold PC
FORWARD_stallID  output  1  hold IF_ID
FORWARD_stallEX  output  1  hold ID_EX
FORWARD_stallME  output  1  hold EX_MEM
FORWARD_stallWB  output  1  hold MEM_WB (commit suppressed)
FORWARD_flushIF  output  1  bubble IF_ID
FORWARD_flushID  output  1  bubble ID_EX
FORWARD_flushEX  output  1  bubble EX_MEM
FORWARD_flushME  output  1  bubble MEM_WB
ctrl_halted  output  1  pipeline frozen after halt
ctrl_stall_cnt  output  CNT_WIDTH  stall-cycle count

Behaviour:
- Outputs are combinational from state and inputs. While rst=1, all stall/flush outputs are 0.
- Reset values: mem FSM=M_IDLE, kill_pending=0, ctrl_halted=0, ctrl_stall_cnt=0.
- mem FSM (M_IDLE, M_WAIT):
  - M_IDLE: mem_stall = MEM_o_mem_req & ~LSU_o_done. Goes to M_WAIT if mem_stall.
  - M_WAIT: mem_stall = ~LSU_o_done. Returns to M_IDLE on LSU_o_done.
  - A same-cycle req+done is a zero-stall access.
- load_use = EXU_o_mem_to_reg & EXU_o_rd != 0 & ((use_rs1 & rs1==rd) | (use_rs2 & rs2==rd)).
- fetch_stall = ~IFU_o_valid | kill_pending.
- Per-cycle priority, first match wins; signals not listed are 0:
  1. ctrl_halted: all five stalls=1, all flushes=0.
  2. mem_stall: stallIF/ID/EX/ME=1, flushME=1, stallWB=0. One bubble enters WB per wait cycle, so there is no double commit. EXU_o_redirect is ignored because EX is held and the redirect re-presents on the release cycle.
  3. EXU_o_redirect: flushIF=1, flushID=1, stallIF=0 (PC takes target). If IFU_o_valid=0 this cycle, set kill_pending.
  4. load_use: stallIF=1, stallID=1, flushID=1 (one bubble, 1-cycle penalty).
  5. fetch_stall: stallIF=1, flushIF=1. If kill_pending & IFU_o_valid, the stale instruction is dropped and kill_pending clears next cycle.
- kill_pending: set per rule 3; cleared on the first cycle with IFU_o_valid=1 while set. Redirect-and-set in the same cycle has set priority. Redirect-while-set keeps it set.
- ctrl_halted: set the cycle after WB_i_system_halt=1. It is sticky and is cleared only by rst.
- ctrl_stall_cnt: +1 each cycle FORWARD_stallIF=1 and ctrl_halted=0. It saturates at all-ones and does not wrap.
- rst mid-LSU-wait returns the FSM to M_IDLE and drops kill_pending. Any late LSU_o_done after reset is ignored in M_IDLE unless MEM_o_mem_req=1.

Test Plan:
- MEM_o_mem_req=1, LSU_o_done after 3 cycles -> stallIF/ID/EX/ME=1 and flushME=1 for 3 cycles, FSM M_WAIT; release on done; ctrl_stall_cnt=3.
- EX load rd=5, ID rs2=5 use_rs2=1 -> stallIF=stallID=flushID=1 for exactly 1 cycle. Repeat with rd=0 -> no stall.
- EXU_o_redirect with IFU_o_valid=0, then valid after 2 cycles -> kill_pending=1. The first valid instruction is flushed (flushIF=1) and the next valid one is passed.
- Redirect and load_use in the same cycle -> flushIF=flushID=1, stallIF=0, stallID=0.
- Redirect during mem_stall -> only mem_stall outputs. On the LSU_o_done cycle, redirect flushes take effect.
- WB_i_system_halt pulse -> next cycle ctrl_halted=1 and all stalls=1; counter frozen; rst clears all state to reset values.
